// File: rtl/stumps_session_ctrl.sv
// stumps_session_ctrl: multi-session STUMPS BIST sequencer (PRPG/CUT/MISR).
// Define STUMPS_CFG_TIMEOUT_EN to add the CFG timeout (CFG_TIMEOUT) and cfg_err.
module stumps_session_ctrl #(
  parameter int SHIFT_CNT    = 15,
  parameter int NUM_TST_CYCL = 5,
  parameter int NUM_SESSIONS = 4,
  parameter int SIG_W        = 44,
`ifdef STUMPS_CFG_TIMEOUT_EN
  parameter int CFG_TIMEOUT  = 64,
`endif
  localparam int SW = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1,
  localparam int FW = $clog2(NUM_SESSIONS + 1)
) (
  input  logic             clk,
  input  logic             masterRst,
  input  logic             start,
  output logic             cfg_req,
  input  logic             cfg_ack,
  input  logic [SIG_W-1:0] sig_in,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [SW-1:0]    session_idx,
  output logic             NbarT,
  output logic             internalRst,
  output logic             PRPG_En,
  output logic             PRPG2_En,
  output logic             MISR_En,
  output logic             MISR2_En,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [FW-1:0]    fail_cnt,
  output logic [SW-1:0]    first_fail
`ifdef STUMPS_CFG_TIMEOUT_EN
  ,
  output logic             cfg_err
`endif
);

  localparam int CW = (SHIFT_CNT > 1) ? $clog2(SHIFT_CNT) : 1;
  localparam int RW = (NUM_TST_CYCL > 1) ? $clog2(NUM_TST_CYCL) : 1;

  typedef enum logic [2:0] {
    IDLE, CFG, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, FIN
  } state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    round;
  logic [SIG_W-1:0] golden_q;
  logic             last_shift;
  logic             last_round;
  logic             last_sess;
  logic             mism;
  logic             tmo;

  assign last_shift = (cnt == CW'(SHIFT_CNT - 1));
  assign last_round = (round == RW'(NUM_TST_CYCL - 1));
  assign last_sess  = (session_idx == SW'(NUM_SESSIONS - 1));
  assign mism       = (sig_in != golden_q);

`ifdef STUMPS_CFG_TIMEOUT_EN
  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign tmo = !cfg_ack && (tcnt == TW'(CFG_TIMEOUT - 1));

  always_ff @(posedge clk or negedge masterRst) begin
    if (!masterRst) begin
      tcnt    <= '0;
      cfg_err <= 1'b0;
    end else begin
      tcnt <= (state == CFG) ? tcnt + 1'b1 : '0;
      if (state == IDLE && start)
        cfg_err <= 1'b0;
      else if (state == CFG && tmo)
        cfg_err <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge masterRst) begin
    if (!masterRst) state <= IDLE;
    else            state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = CFG;
      CFG: begin
        if (cfg_ack)  nxt = SEED;
        else if (tmo) nxt = FIN;
      end
      SEED:    nxt = SHIFT;
      SHIFT:   if (last_shift) nxt = CAPTURE;
      CAPTURE: nxt = last_round ? UNLOAD : SHIFT;
      UNLOAD:  if (last_shift) nxt = COMPARE;
      COMPARE: nxt = last_sess ? FIN : CFG;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_req     = 1'b0;
    NbarT       = 1'b1;
    internalRst = 1'b0;
    PRPG_En     = 1'b0;
    PRPG2_En    = 1'b0;
    MISR_En     = 1'b0;
    MISR2_En    = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      CFG:  cfg_req     = 1'b1;
      SEED: internalRst = 1'b1;
      SHIFT, UNLOAD: begin
        PRPG_En  = 1'b1;
        PRPG2_En = 1'b1;
        MISR2_En = 1'b1;
      end
      CAPTURE: begin
        NbarT   = 1'b0;
        MISR_En = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Shift counter wraps on its own so every SHIFT/UNLOAD burst starts at 0.
  always_ff @(posedge clk or negedge masterRst) begin
    if (!masterRst) begin
      cnt   <= '0;
      round <= '0;
    end else begin
      if (state == SHIFT || state == UNLOAD)
        cnt <= last_shift ? '0 : cnt + 1'b1;
      else
        cnt <= '0;
      if (state == SEED)
        round <= '0;
      else if (state == CAPTURE)
        round <= round + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge masterRst) begin
    if (!masterRst) begin
      session_idx <= '0;
      fail_cnt    <= '0;
      first_fail  <= '0;
      pass        <= 1'b1;
      golden_q    <= '0;
    end else if (state == IDLE && start) begin
      session_idx <= '0;
      fail_cnt    <= '0;
      first_fail  <= '0;
      pass        <= 1'b1;
    end else if (state == CFG) begin
      if (cfg_ack)  golden_q <= golden_sig;
      else if (tmo) pass     <= 1'b0;
    end else if (state == COMPARE) begin
      if (mism) begin
        fail_cnt <= fail_cnt + 1'b1;
        pass     <= 1'b0;
        if (fail_cnt == '0) first_fail <= session_idx;
      end
      if (!last_sess) session_idx <= session_idx + 1'b1;
    end
  end

endmodule
